// File: rtl/c2s_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : c2s_arb_pkg
// Brief    : Shared types, constants and round-robin helper for the C2S arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef C2SIF_DATA_SIZE
`define C2SIF_DATA_SIZE 8
`endif

package c2s_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_MACK = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_t;

   localparam logic [31:0] RET_TIMEOUT = 32'hFFFF_FFFF;
   localparam int          RR_MAX      = 16;
   localparam int          RR_IW       = 4;

   // First set bit of req[n-1:0] scanning upward from ptr with wrap; 0 if none.
   function automatic int rr_pick(input logic [RR_MAX-1:0] req,
                                  input int                ptr,
                                  input int                n);
      int   k;
      logic found;
      rr_pick = 0;
      found   = 1'b0;
      for (int i = 0; i < RR_MAX; i++) begin
         if (i < n) begin
            k = ptr + i;
            if (k >= n) k = k - n;
            if (!found && req[k[RR_IW-1:0]]) begin
               found   = 1'b1;
               rr_pick = k;
            end
         end
      end
   endfunction

endpackage

// File: rtl/c2s_rr_pick.sv
//------------------------------------------------------------------------------
// Module   : c2s_rr_pick
// Brief    : Combinational round-robin picker (first request at or after ptr).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module c2s_rr_pick
   import c2s_arb_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IW-1:0]    i_ptr,
   output logic             o_valid,
   output logic [IW-1:0]    o_idx
);

   always_comb begin
      o_valid = |i_req;
      o_idx   = IW'(rr_pick(RR_MAX'(i_req), int'(i_ptr), N_REQ));
   end

endmodule

`default_nettype wire

// File: rtl/c2s_arbiter.sv
//------------------------------------------------------------------------------
// Module   : c2s_arbiter
// Brief    : Round-robin arbiter sharing one 4-phase C2S request channel.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module c2s_arbiter
   import c2s_arb_pkg::*;
#(
   parameter  int N_REQ       = 4,
   parameter  int DATA_SIZE   = `C2SIF_DATA_SIZE,
   parameter  int TIMEOUT_CYC = 1024,
   localparam int GW          = $clog2(N_REQ),
   localparam int DW          = DATA_SIZE * 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      s_req,
   output logic [N_REQ-1:0]      s_ack,
   input  logic [N_REQ*32-1:0]   s_id,
   input  logic [N_REQ*32-1:0]   s_fn,
   input  logic [N_REQ*32-1:0]   s_addr,
   input  logic [N_REQ*DW-1:0]   s_data,
   output logic [31:0]           s_ret,
   output logic                  m_req,
   input  logic                  m_ack,
   output logic [31:0]           m_id,
   output logic [31:0]           m_fn,
   output logic [31:0]           m_addr,
   output logic [DW-1:0]         m_data,
   input  logic [31:0]           m_ret,
   output logic [GW-1:0]         grant_id,
   output logic                  busy,
   output logic                  timeout_err
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;

   logic [GW-1:0]     r_rr_ptr;
   logic [GW-1:0]     r_grant_id;
   logic [31:0]       r_tmo;
   logic [N_REQ-1:0]  r_s_ack;
   logic [31:0]       r_s_ret;
   logic              r_m_req;
   logic [31:0]       r_m_id;
   logic [31:0]       r_m_fn;
   logic [31:0]       r_m_addr;
   logic [DW-1:0]     r_m_data;
   logic              r_timeout_err;

   logic              w_pick_valid;
   logic [GW-1:0]     w_pick_idx;
   logic              w_grant;
   logic              w_ack_ok;
   logic              w_abort;
   logic              w_release;
   logic [N_REQ-1:0]  w_ack_vec;

   logic [31:0]       w_id_arr   [N_REQ];
   logic [31:0]       w_fn_arr   [N_REQ];
   logic [31:0]       w_addr_arr [N_REQ];
   logic [DW-1:0]     w_data_arr [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_id_arr[gi]   = s_id[gi*32 +: 32];
      assign w_fn_arr[gi]   = s_fn[gi*32 +: 32];
      assign w_addr_arr[gi] = s_addr[gi*32 +: 32];
      assign w_data_arr[gi] = s_data[gi*DW +: DW];
   end

   c2s_rr_pick #(
      .N_REQ   (N_REQ)
   ) u_pick (
      .i_req   (s_req),
      .i_ptr   (r_rr_ptr),
      .o_valid (w_pick_valid),
      .o_idx   (w_pick_idx)
   );

   assign w_ack_vec = N_REQ'(1) << r_grant_id;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_ack_ok    = 1'b0;
      w_abort     = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         IDLE: begin
            // A held m_ack belongs to an aborted transaction; let it drain first.
            if (!m_ack && w_pick_valid) begin
               w_grant     = 1'b1;
               w_state_nxt = WAIT_MACK;
            end
         end
         WAIT_MACK: begin
            if (m_ack) begin
               w_ack_ok    = 1'b1;
               w_state_nxt = WAIT_DONE;
            end else if ((TIMEOUT_CYC != 0) && (r_tmo == '0)) begin
               w_abort     = 1'b1;
               w_state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!s_req[r_grant_id] && !m_ack) begin
               w_release   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr      <= '0;
         r_grant_id    <= '0;
         r_tmo         <= '0;
         r_s_ack       <= '0;
         r_s_ret       <= '0;
         r_m_req       <= 1'b0;
         r_m_id        <= '0;
         r_m_fn        <= '0;
         r_m_addr      <= '0;
         r_m_data      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_abort;
         if (w_grant) begin
            r_m_id     <= w_id_arr[w_pick_idx];
            r_m_fn     <= w_fn_arr[w_pick_idx];
            r_m_addr   <= w_addr_arr[w_pick_idx];
            r_m_data   <= w_data_arr[w_pick_idx];
            r_grant_id <= w_pick_idx;
            r_m_req    <= 1'b1;
            r_rr_ptr   <= (w_pick_idx == GW'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
            // Counter reaching zero marks TIMEOUT_CYC cycles spent waiting.
            r_tmo      <= 32'(TIMEOUT_CYC - 1);
         end
         if (r_state == WAIT_MACK && !m_ack && r_tmo != '0) begin
            r_tmo <= r_tmo - 32'd1;
         end
         if (w_ack_ok) begin
            r_s_ret <= m_ret;
            r_m_req <= 1'b0;
            r_s_ack <= w_ack_vec;
         end
         if (w_abort) begin
            r_s_ret <= RET_TIMEOUT;
            r_m_req <= 1'b0;
            r_s_ack <= w_ack_vec;
         end
         if (w_release) begin
            r_s_ack <= '0;
         end
      end
   end

   assign s_ack       = r_s_ack;
   assign s_ret       = r_s_ret;
   assign m_req       = r_m_req;
   assign m_id        = r_m_id;
   assign m_fn        = r_m_fn;
   assign m_addr      = r_m_addr;
   assign m_data      = r_m_data;
   assign grant_id    = r_grant_id;
   assign busy        = (r_state != IDLE);
   assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_c2s_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_c2s_arbiter
// Brief    : Directed self-checking bench for c2s_arbiter and c2s_rr_pick.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_c2s_arbiter;

   localparam int N   = 4;
   localparam int DS  = 8;
   localparam int TMO = 16;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      s_req = '0;
   logic [N-1:0]      s_ack;
   logic [N*32-1:0]   s_id;
   logic [N*32-1:0]   s_fn;
   logic [N*32-1:0]   s_addr;
   logic [N*DS*32-1:0] s_data;
   logic [31:0]       s_ret;
   logic              m_req;
   logic              m_ack = 1'b0;
   logic [31:0]       m_id;
   logic [31:0]       m_fn;
   logic [31:0]       m_addr;
   logic [DS*32-1:0]  m_data;
   logic [31:0]       m_ret = '0;
   logic [1:0]        grant_id;
   logic              busy;
   logic              timeout_err;

   logic [3:0]        pk_req = '0;
   logic [1:0]        pk_ptr = '0;
   logic              pk_valid;
   logic [1:0]        pk_idx;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   c2s_arbiter #(
      .N_REQ       (N),
      .DATA_SIZE   (DS),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_req       (s_req),
      .s_ack       (s_ack),
      .s_id        (s_id),
      .s_fn        (s_fn),
      .s_addr      (s_addr),
      .s_data      (s_data),
      .s_ret       (s_ret),
      .m_req       (m_req),
      .m_ack       (m_ack),
      .m_id        (m_id),
      .m_fn        (m_fn),
      .m_addr      (m_addr),
      .m_data      (m_data),
      .m_ret       (m_ret),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   c2s_rr_pick #(
      .N_REQ   (N)
   ) u_pick (
      .i_req   (pk_req),
      .i_ptr   (pk_ptr),
      .o_valid (pk_valid),
      .o_idx   (pk_idx)
   );

   localparam logic [3:0] PK_REQ [7] = '{4'b1111, 4'b1111, 4'b1010, 4'b0010, 4'b1000, 4'b0101, 4'b0000};
   localparam logic [1:0] PK_PTR [7] = '{2'd0,    2'd2,    2'd3,    2'd3,    2'd0,    2'd1,    2'd1};
   localparam logic       PK_VLD [7] = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b0};
   localparam logic [1:0] PK_IDX [7] = '{2'd0,    2'd2,    2'd3,    2'd1,    2'd3,    2'd2,    2'd0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Responder + requester for one transaction granted to gid.
   task automatic serve(input int gid, input logic [31:0] ret, input int lat, input bit rereq);
      int k;
      k = 0;
      while (!m_req && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("serve_m_req", 32'(m_req), 32'd1);
      chk("serve_grant", 32'(grant_id), 32'(gid));
      chk("serve_m_id", m_id, 32'h10 + 32'(gid));
      repeat (lat) @(negedge clk);
      m_ack = 1'b1;
      m_ret = ret;
      @(negedge clk);
      chk("serve_s_ack", 32'(s_ack), 32'd1 << gid);
      chk("serve_s_ret", s_ret, ret);
      chk("serve_m_req_low", 32'(m_req), 32'd0);
      m_ack = 1'b0;
      s_req[gid] = 1'b0;
      @(negedge clk);
      chk("serve_release", 32'(s_ack), 32'd0);
      chk("serve_idle", 32'(busy), 32'd0);
      if (rereq) s_req[gid] = 1'b1;
   endtask

   initial begin
      s_data = '0;
      for (int i = 0; i < N; i++) begin
         s_id[i*32 +: 32]   = 32'h10 + 32'(i);
         s_fn[i*32 +: 32]   = 32'h20 + 32'(i);
         s_addr[i*32 +: 32] = 32'h1000 + 32'(i);
      end

      // Picker unit vectors
      for (int t = 0; t < 7; t++) begin
         pk_req = PK_REQ[t];
         pk_ptr = PK_PTR[t];
         #1;
         chk("pick_valid", 32'(pk_valid), 32'(PK_VLD[t]));
         if (PK_VLD[t]) chk("pick_idx", 32'(pk_idx), 32'(PK_IDX[t]));
      end

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_m_req", 32'(m_req), 32'd0);
      chk("rst_s_ack", 32'(s_ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      chk("rst_tmo_err", 32'(timeout_err), 32'd0);
      chk("rst_s_ret", s_ret, 32'd0);
      chk("rst_m_addr", m_addr, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single request from requester 2
      s_id[2*32 +: 32]        = 32'd5;
      s_addr[2*32 +: 32]      = 32'h100;
      s_data[(2*DS)*32 +: 32] = 32'hA5;
      s_req[2] = 1'b1;
      chk("single_pre_m_req", 32'(m_req), 32'd0);
      @(negedge clk);
      chk("single_m_req", 32'(m_req), 32'd1);
      chk("single_grant", 32'(grant_id), 32'd2);
      chk("single_m_addr", m_addr, 32'h100);
      chk("single_m_id", m_id, 32'd5);
      chk("single_m_fn", m_fn, 32'h22);
      chk("single_m_data0", m_data[31:0], 32'hA5);
      chk("single_busy", 32'(busy), 32'd1);
      chk("single_no_ack", 32'(s_ack), 32'd0);
      repeat (2) @(negedge clk);
      chk("single_m_req_hold", 32'(m_req), 32'd1);
      m_ack = 1'b1;
      m_ret = 32'h1234;
      @(negedge clk);
      chk("single_s_ack", 32'(s_ack), 32'b0100);
      chk("single_s_ret", s_ret, 32'h1234);
      chk("single_m_req_low", 32'(m_req), 32'd0);
      m_ack = 1'b0;
      @(negedge clk);
      chk("single_ack_hold", 32'(s_ack), 32'b0100);
      s_req[2] = 1'b0;
      @(negedge clk);
      chk("single_ack_drop", 32'(s_ack), 32'd0);
      chk("single_idle", 32'(busy), 32'd0);
      chk("single_ret_keep", s_ret, 32'h1234);
      chk("single_addr_keep", m_addr, 32'h100);
      s_id[2*32 +: 32] = 32'h12;

      // Wrap-around from pointer 3: requests 1 and 3
      s_req = 4'b1010;
      serve(3, 32'hA3, 1, 1'b0);
      serve(1, 32'hA1, 2, 1'b0);
      // Pointer now 2: of requests 1 and 2, 2 must win
      s_req = 4'b0110;
      serve(2, 32'hB2, 0, 1'b0);
      serve(1, 32'hB1, 0, 1'b0);

      // Timeout: responder never acks
      s_req[0] = 1'b1;
      @(negedge clk);
      chk("tmo_m_req", 32'(m_req), 32'd1);
      chk("tmo_grant", 32'(grant_id), 32'd0);
      repeat (15) @(negedge clk);
      chk("tmo_m_req_hold", 32'(m_req), 32'd1);
      chk("tmo_err_early", 32'(timeout_err), 32'd0);
      @(negedge clk);
      chk("tmo_m_req_drop", 32'(m_req), 32'd0);
      chk("tmo_err_pulse", 32'(timeout_err), 32'd1);
      chk("tmo_s_ret", s_ret, 32'hFFFF_FFFF);
      chk("tmo_s_ack", 32'(s_ack), 32'b0001);
      s_req[0] = 1'b0;
      @(negedge clk);
      chk("tmo_err_once", 32'(timeout_err), 32'd0);
      chk("tmo_release", 32'(s_ack), 32'd0);
      // Late ack must hold the arbiter in IDLE
      m_ack = 1'b1;
      s_req[3] = 1'b1;
      @(negedge clk);
      chk("late_ack_idle", 32'(busy), 32'd0);
      chk("late_ack_no_req", 32'(m_req), 32'd0);
      @(negedge clk);
      chk("late_ack_idle2", 32'(busy), 32'd0);
      m_ack = 1'b0;
      serve(3, 32'hC3, 1, 1'b0);

      // Reset during WAIT_MACK
      s_req[1] = 1'b1;
      @(negedge clk);
      chk("midrst_m_req", 32'(m_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_m_req_low", 32'(m_req), 32'd0);
      chk("midrst_s_ack", 32'(s_ack), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      s_req[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Contention with pointer back at 0
      s_req = 4'b1111;
      serve(0, 32'hD0, 1, 1'b1);
      serve(1, 32'hD1, 1, 1'b1);
      serve(2, 32'hD2, 1, 1'b1);
      serve(3, 32'hD3, 1, 1'b1);
      serve(0, 32'hD4, 1, 1'b0);
      s_req = '0;
      @(negedge clk);

      // Early drop by requester 1 (pointer now 1)
      s_req[1] = 1'b1;
      @(negedge clk);
      chk("drop_m_req", 32'(m_req), 32'd1);
      chk("drop_grant", 32'(grant_id), 32'd1);
      s_req[1] = 1'b0;
      @(negedge clk);
      chk("drop_still_wait", 32'(m_req), 32'd1);
      m_ack = 1'b1;
      m_ret = 32'hBEEF;
      @(negedge clk);
      chk("drop_s_ack", 32'(s_ack), 32'b0010);
      chk("drop_s_ret", s_ret, 32'hBEEF);
      m_ack = 1'b0;
      @(negedge clk);
      chk("drop_ack_1cyc", 32'(s_ack), 32'd0);
      chk("drop_idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, observed running expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
